// File: rtl/stream_unzip_if.sv
// rtl/stream_unzip_if.sv - handshake bundle between producer, unzip and the two lane consumers
interface stream_unzip_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sIn;
  logic             sIn_valid;
  logic             sIn_ready;
  logic [WIDTH-1:0] sOutA;
  logic             sOutA_valid;
  logic             sOutA_ready;
  logic [WIDTH-1:0] sOutB;
  logic             sOutB_valid;
  logic             sOutB_ready;

  // Producer and lane consumers together drive the inputs of the unzip block.
  modport master (
    output sIn, sIn_valid, sOutA_ready, sOutB_ready,
    input  sIn_ready, sOutA, sOutA_valid, sOutB, sOutB_valid
  );

  // The unzip block itself.
  modport slave (
    input  sIn, sIn_valid, sOutA_ready, sOutB_ready,
    output sIn_ready, sOutA, sOutA_valid, sOutB, sOutB_valid
  );
endinterface

// File: rtl/stream_unzip.sv
// rtl/stream_unzip.sv - alternating split of one stream into two FIFO-buffered lanes
module stream_unzip #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             nrst,
  stream_unzip_if.slave    bus,
  output logic             phase
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Lane the next accepted element is steered to.
  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  lane_e state_q;
  lane_e state_d;

  // Per-lane storage: index 0 is lane A, index 1 is lane B.
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];

  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       in_ready;
  logic       accept;

  // Occupancy flags come only from registered counts, so input ready never
  // sees the consumers' ready signals combinationally.
  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]     = (count[i] == CW'(DEPTH));
      nonempty[i] = (count[i] != '0);
    end
  end

  // Lane pops are independent of each other and of the input side.
  always_comb begin
    pop    = '0;
    pop[0] = nonempty[0] && bus.sOutA_ready;
    pop[1] = nonempty[1] && bus.sOutB_ready;
  end

  // Steering FSM: target lane full stalls input; accept pushes and flips lane.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    push     = '0;
    case (state_q)
      LANE_A: begin
        in_ready = !full[0];
        accept   = bus.sIn_valid && in_ready;
        if (accept) begin
          push[0] = 1'b1;
          state_d = LANE_B;
        end
      end
      LANE_B: begin
        in_ready = !full[1];
        accept   = bus.sIn_valid && in_ready;
        if (accept) begin
          push[1] = 1'b1;
          state_d = LANE_A;
        end
      end
      default: begin
        state_d = LANE_A;
      end
    endcase
  end

  // Steering state register; reset restarts the alternation on lane A.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= LANE_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Lane FIFOs: storage cleared on reset so idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= bus.sIn;
          wr_ptr[i]         <= wr_ptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign bus.sIn_ready   = in_ready;
  assign bus.sOutA       = mem[0][rd_ptr[0]];
  assign bus.sOutA_valid = nonempty[0];
  assign bus.sOutB       = mem[1][rd_ptr[1]];
  assign bus.sOutB_valid = nonempty[1];
  assign phase           = state_q;

endmodule

// File: tb/tb_stream_unzip.sv
// tb/tb_stream_unzip.sv - directed scoreboard bench for stream_unzip
module tb_stream_unzip;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic nrst;
  logic phase;

  stream_unzip_if #(.WIDTH(WIDTH)) bus ();

  stream_unzip #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .bus   (bus),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic             m_phase = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sIn_valid = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] v, output int waited);
    logic acc;
    bus.sIn       = v;
    bus.sIn_valid = 1'b1;
    waited        = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = bus.sIn_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        waited = k;
        return;
      end
    end
    checks++;
    failures++;
    $error("FAIL send_timeout observed=%0h expected=accept", v);
    waited = 40;
  endtask

  // Reference model: compares registered outputs, then applies this cycle's edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      logic popa;
      logic popb;
      exp_rdy = ((m_phase == 1'b0) ? qa.size() : qb.size()) < DEPTH;
      chk("in_ready", 32'(bus.sIn_ready), 32'(exp_rdy));
      chk("phase", 32'(phase), 32'(m_phase));
      chk("a_valid", 32'(bus.sOutA_valid), 32'(qa.size() != 0));
      chk("b_valid", 32'(bus.sOutB_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) chk("a_data", 32'(bus.sOutA), 32'(qa[0]));
      if (qb.size() != 0) chk("b_data", 32'(bus.sOutB), 32'(qb[0]));
      if (!nrst) begin
        qa.delete();
        qb.delete();
        m_phase = 1'b0;
      end else begin
        popa = (qa.size() != 0) && bus.sOutA_ready;
        popb = (qb.size() != 0) && bus.sOutB_ready;
        if (popa) void'(qa.pop_front());
        if (popb) void'(qb.pop_front());
        if (bus.sIn_valid && exp_rdy) begin
          if (m_phase == 1'b0) qa.push_back(bus.sIn);
          else                 qb.push_back(bus.sIn);
          m_phase = ~m_phase;
        end
      end
    end
  end

  initial begin
    int   w;
    logic ph;
    nrst            = 1'b0;
    bus.sIn         = '0;
    bus.sIn_valid   = 1'b0;
    bus.sOutA_ready = 1'b0;
    bus.sOutB_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_a_valid", 32'(bus.sOutA_valid), 32'd0);
    chk("rst_b_valid", 32'(bus.sOutB_valid), 32'd0);
    chk("rst_a_data", 32'(bus.sOutA), 32'd0);
    chk("rst_b_data", 32'(bus.sOutB), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    nrst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.sIn_ready), 32'd1);

    // T1 basic back-to-back alternation
    bus.sOutA_ready = 1'b1;
    bus.sOutB_ready = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      send(WIDTH'(v), w);
      chk("t1_no_stall", 32'(w), 32'd0);
      if (v == 1) begin
        chk("t1_lat_valid", 32'(bus.sOutA_valid), 32'd1);
        chk("t1_lat_data", 32'(bus.sOutA), 32'd1);
      end
    end
    idle();
    repeat (3) tick();

    // T2 lane B stalled: B fills with 11,13, input blocks once 15 targets B
    bus.sOutB_ready = 1'b0;
    for (int v = 10; v <= 14; v++) send(WIDTH'(v), w);
    bus.sIn = 8'd15;
    tick();
    tick();
    chk("t2_stall_ready", 32'(bus.sIn_ready), 32'd0);
    chk("t2_stall_phase", 32'(phase), 32'd1);
    chk("t2_b_head", 32'(bus.sOutB), 32'd11);
    bus.sOutB_ready = 1'b1;
    for (int v = 15; v <= 17; v++) send(WIDTH'(v), w);
    idle();
    repeat (4) tick();

    // T3 hold stable while lane A consumer is not ready
    bus.sOutA_ready = 1'b0;
    send(8'd7, w);
    idle();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_data", 32'(bus.sOutA), 32'd7);
      chk("t3_hold_valid", 32'(bus.sOutA_valid), 32'd1);
      tick();
    end
    bus.sOutA_ready = 1'b1;
    tick();
    chk("t3_after_pop", 32'(bus.sOutA_valid), 32'd0);

    // T4 bubbles: phase moves only on accepted cycles
    send(8'd8, w);
    idle();
    tick();
    chk("t4_phase0", 32'(phase), 32'd0);
    ph = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.sIn       = WIDTH'(2 * k);
      bus.sIn_valid = 1'b1;
      tick();
      ph = ~ph;
      chk("t4_phase_acc", 32'(phase), 32'(ph));
      if (k == 0) chk("t4_a_first", 32'(bus.sOutA), 32'd0);
      bus.sIn_valid = 1'b0;
      tick();
      chk("t4_phase_hold", 32'(phase), 32'(ph));
    end
    repeat (3) tick();

    // T5 lane A full with pop in the same cycle
    bus.sOutA_ready = 1'b0;
    send(8'h21, w);
    send(8'h31, w);
    send(8'h22, w);
    send(8'h32, w);
    idle();
    tick();
    bus.sIn         = 8'h55;
    bus.sIn_valid   = 1'b1;
    bus.sOutA_ready = 1'b1;
    #1;
    chk("t5_full_ready", 32'(bus.sIn_ready), 32'd0);
    tick();
    chk("t5_space_ready", 32'(bus.sIn_ready), 32'd1);
    chk("t5_a_head", 32'(bus.sOutA), 32'h22);
    bus.sOutA_ready = 1'b0;
    tick();
    idle();
    chk("t5_phase", 32'(phase), 32'd1);
    bus.sOutA_ready = 1'b1;
    repeat (4) tick();

    // T6 reset with three elements buffered and phase on lane B
    send(8'h60, w);
    idle();
    tick();
    bus.sOutA_ready = 1'b0;
    bus.sOutB_ready = 1'b0;
    send(8'h61, w);
    send(8'h62, w);
    send(8'h63, w);
    idle();
    chk("t6_pre_phase", 32'(phase), 32'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t6_a_valid", 32'(bus.sOutA_valid), 32'd0);
    chk("t6_b_valid", 32'(bus.sOutB_valid), 32'd0);
    chk("t6_phase", 32'(phase), 32'd0);
    chk("t6_a_data", 32'(bus.sOutA), 32'd0);
    bus.sOutA_ready = 1'b1;
    bus.sOutB_ready = 1'b1;
    send(8'd99, w);
    idle();
    chk("t6_a_99", 32'(bus.sOutA), 32'd99);
    chk("t6_a_99_valid", 32'(bus.sOutA_valid), 32'd1);
    chk("t6_b_idle", 32'(bus.sOutB_valid), 32'd0);
    repeat (3) tick();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
